// File: rtl/lib_arbiter_pkg.sv
// Shared widths and types for the arbiter event path and the event packetizer.
package lib_arbiter_pkg;
  localparam int ROW_ADD  = 11;
  localparam int COL_ADD  = 11;
  localparam int POLARITY = 2;
  localparam int SIZE     = 34;
  localparam int WIDTH    = 32;

  localparam int EV_W = ROW_ADD + COL_ADD + POLARITY + SIZE;

  localparam logic [1:0] TAG_W0 = 2'b10;
  localparam logic [1:0] TAG_W1 = 2'b01;

  // Timestamp split: upper bits ride in word0, the rest fill word1 below its tag and pad.
  localparam int TS_HI_W = WIDTH - 2 - POLARITY - ROW_ADD - COL_ADD;
  localparam int TS_LO_W = SIZE - TS_HI_W;

  typedef struct packed {
    logic [POLARITY-1:0] polarity;
    logic [ROW_ADD-1:0]  x_add;
    logic [COL_ADD-1:0]  y_add;
    logic [SIZE-1:0]     timestamp;
  } event_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_W0 = 2'd1,
    SEND_W1 = 2'd2
  } pk_state_e;
endpackage

// File: rtl/event_packetizer_if.sv
// Event-in / word-out bundle of the packetizer; slave is the packetizer side.
interface event_packetizer_if
  import lib_arbiter_pkg::*;
#(
  parameter int DROP_CNT_W = 16
);
  logic                  ev_valid_i;
  logic [ROW_ADD-1:0]    x_add_i;
  logic [COL_ADD-1:0]    y_add_i;
  logic [POLARITY-1:0]   polarity_i;
  logic [SIZE-1:0]       timestamp_i;
  logic [WIDTH-1:0]      data_o;
  logic                  data_valid_o;
  logic                  data_ready_i;
  logic                  fifo_full_o;
  logic                  fifo_empty_o;
  logic [DROP_CNT_W-1:0] drop_cnt_o;

  modport master (
    output ev_valid_i, x_add_i, y_add_i, polarity_i, timestamp_i, data_ready_i,
    input  data_o, data_valid_o, fifo_full_o, fifo_empty_o, drop_cnt_o
  );

  modport slave (
    input  ev_valid_i, x_add_i, y_add_i, polarity_i, timestamp_i, data_ready_i,
    output data_o, data_valid_o, fifo_full_o, fifo_empty_o, drop_cnt_o
  );
endinterface

// File: rtl/event_fifo.sv
// Synchronous show-ahead event FIFO; head entry is readable combinationally.
module event_fifo
  import lib_arbiter_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic   clk_i,
  input  logic   reset_i,
  input  logic   push,
  input  logic   pop,
  input  event_t wr_data,
  output event_t rd_data,
  output logic   full,
  output logic   empty
);
  localparam int AW = $clog2(DEPTH);

  event_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Pointers are exactly AW bits wide, so wrap modulo DEPTH is free.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/event_packetizer.sv
// Buffers arbiter events and streams each one out as a tagged two-word packet.
module event_packetizer
  import lib_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DROP_CNT_W = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  event_packetizer_if.slave bus
);
  event_t                wr_ev;
  event_t                head_ev;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic                  load_w0;
  logic                  load_w1;
  pk_state_e             state_p1;
  pk_state_e             state_d;
  logic [WIDTH-1:0]      data_p1;
  logic [TS_LO_W-1:0]    ts_lo_p1;
  logic                  vld_p1;
  logic [DROP_CNT_W-1:0] drop_cnt;

  function automatic logic [WIDTH-1:0] pack_w0(input event_t ev);
    return {TAG_W0, ev.polarity, ev.x_add, ev.y_add, ev.timestamp[SIZE-1 -: TS_HI_W]};
  endfunction

  function automatic logic [WIDTH-1:0] pack_w1(input logic [TS_LO_W-1:0] ts_lo);
    return {TAG_W1, 2'b00, ts_lo};
  endfunction

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Stage p0: event capture into the FIFO
  assign wr_ev = '{polarity:  bus.polarity_i,
                   x_add:     bus.x_add_i,
                   y_add:     bus.y_add_i,
                   timestamp: bus.timestamp_i};
  assign push  = bus.ev_valid_i && !fifo_full;

  event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_ev),
    .rd_data (head_ev),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // A full FIFO drops the event even when a pop frees a slot this same cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i)                           drop_cnt <= '0;
    else if (bus.ev_valid_i && fifo_full)  drop_cnt <= sat_inc(drop_cnt);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state_p1 <= IDLE;
    else         state_p1 <= state_d;
  end

  always_comb begin
    state_d = state_p1;
    pop     = 1'b0;
    load_w0 = 1'b0;
    load_w1 = 1'b0;
    case (state_p1)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          load_w0 = 1'b1;
          state_d = SEND_W0;
        end
      end
      SEND_W0: begin
        if (bus.data_ready_i) begin
          load_w1 = 1'b1;
          state_d = SEND_W1;
        end
      end
      SEND_W1: begin
        if (bus.data_ready_i) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            load_w0 = 1'b1;
            state_d = SEND_W0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p1: output word register; holds while the consumer stalls
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_p1  <= '0;
      ts_lo_p1 <= '0;
    end else if (load_w0) begin
      data_p1  <= pack_w0(head_ev);
      ts_lo_p1 <= head_ev.timestamp[TS_LO_W-1:0];
    end else if (load_w1) begin
      data_p1  <= pack_w1(ts_lo_p1);
    end
  end

  assign vld_p1 = (state_p1 == SEND_W0) || (state_p1 == SEND_W1);

  assign bus.data_o       = data_p1;
  assign bus.data_valid_o = vld_p1;
  assign bus.fifo_full_o  = fifo_full;
  assign bus.fifo_empty_o = fifo_empty;
  assign bus.drop_cnt_o   = drop_cnt;
endmodule

// File: tb/tb_event_packetizer.sv
// Directed bench for event_packetizer: latency, backpressure, overflow, streaming, reset, saturation.
module tb_event_packetizer;
  import lib_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  event_packetizer_if #(.DROP_CNT_W(16)) bus ();
  event_packetizer_if #(.DROP_CNT_W(4))  bus4 ();

  event_packetizer #(.FIFO_DEPTH(16), .DROP_CNT_W(16)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  event_packetizer #(.FIFO_DEPTH(16), .DROP_CNT_W(4)) dut4 (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus4)
  );

  function automatic logic [ROW_ADD-1:0] ev_x(input int i);
    return ROW_ADD'(i * 37 + 1);
  endfunction
  function automatic logic [COL_ADD-1:0] ev_y(input int i);
    return COL_ADD'(i * 5 + 2);
  endfunction
  function automatic logic [POLARITY-1:0] ev_pol(input int i);
    return POLARITY'(i);
  endfunction
  function automatic logic [SIZE-1:0] ev_ts(input int i);
    logic [31:0] lo;
    lo = 32'(i) * 32'h0101_0101 + 32'd7;
    return {2'(i + 1), lo};
  endfunction
  function automatic logic [31:0] exp_w0(input int i);
    logic [SIZE-1:0] ts;
    ts = ev_ts(i);
    return {2'b10, ev_pol(i), ev_x(i), ev_y(i), ts[33:28]};
  endfunction
  function automatic logic [31:0] exp_w1(input int i);
    logic [SIZE-1:0] ts;
    ts = ev_ts(i);
    return {2'b01, 2'b00, ts[27:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_raw(input logic [ROW_ADD-1:0] x, input logic [COL_ADD-1:0] y,
                           input logic [POLARITY-1:0] p, input logic [SIZE-1:0] ts);
    bus.ev_valid_i  = 1'b1;
    bus.x_add_i     = x;
    bus.y_add_i     = y;
    bus.polarity_i  = p;
    bus.timestamp_i = ts;
  endtask

  task automatic drive_ev(input int i);
    drive_raw(ev_x(i), ev_y(i), ev_pol(i), ev_ts(i));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.ev_valid_i  = 1'b0;
    bus4.ev_valid_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_ev(3);
    bus.data_ready_i = 1'b1;
    tick();
    tick();
    if (bus.data_o !== 32'h0) begin failures++; $display("FAIL reset_data actual=%h expected=%h", bus.data_o, 32'h0); end
    checks++;
    if (bus.data_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid actual=%b expected=0", bus.data_valid_o); end
    checks++;
    if (bus.fifo_empty_o !== 1'b1) begin failures++; $display("FAIL reset_empty actual=%b expected=1", bus.fifo_empty_o); end
    checks++;
    if (bus.fifo_full_o !== 1'b0) begin failures++; $display("FAIL reset_full actual=%b expected=0", bus.fifo_full_o); end
    checks++;
    if (bus.drop_cnt_o !== 16'h0) begin failures++; $display("FAIL reset_drop actual=%h expected=0", bus.drop_cnt_o); end
    checks++;
    rst = 1'b0;
    bus.ev_valid_i = 1'b0;
    tick();
    tick();
    if (bus.fifo_empty_o !== 1'b1 || bus.data_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_ignores_ev actual=empty%b/valid%b expected=empty1/valid0", bus.fifo_empty_o, bus.data_valid_o);
    end
    checks++;
  endtask

  task automatic test_single();
    do_reset();
    bus.data_ready_i = 1'b1;
    drive_raw(11'd5, 11'd9, 2'b01, 34'h3_0000_0001);
    tick();
    bus.ev_valid_i = 1'b0;
    if (bus.data_valid_o !== 1'b0) begin failures++; $display("FAIL single_cyc1_valid actual=%b expected=0", bus.data_valid_o); end
    checks++;
    tick();
    if (bus.data_valid_o !== 1'b1 || bus.data_o !== 32'h900A_0270) begin
      failures++;
      $display("FAIL single_word0 actual=%b/%h expected=1/900a0270", bus.data_valid_o, bus.data_o);
    end
    checks++;
    tick();
    if (bus.data_valid_o !== 1'b1 || bus.data_o !== 32'h4000_0001) begin
      failures++;
      $display("FAIL single_word1 actual=%b/%h expected=1/40000001", bus.data_valid_o, bus.data_o);
    end
    checks++;
    tick();
    if (bus.data_valid_o !== 1'b0 || bus.fifo_empty_o !== 1'b1) begin
      failures++;
      $display("FAIL single_done actual=valid%b/empty%b expected=valid0/empty1", bus.data_valid_o, bus.fifo_empty_o);
    end
    checks++;
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_seq [4];
    exp_seq[0] = 32'hA006_01EA;
    exp_seq[1] = 32'h4000_0123;
    exp_seq[2] = 32'hBFFE_001F;
    exp_seq[3] = 32'h4FFF_FFFF;
    do_reset();
    bus.data_ready_i = 1'b0;
    drive_raw(11'd3, 11'd7, 2'b10, 34'h2_A000_0123);
    tick();
    drive_raw(11'h7FF, 11'd0, 2'b11, 34'h1_FFFF_FFFF);
    tick();
    bus.ev_valid_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (bus.data_valid_o !== 1'b1 || bus.data_o !== exp_seq[0] || bus.fifo_empty_o !== 1'b0) begin
        failures++;
        $display("FAIL bp_stall%0d actual=%b/%h/empty%b expected=1/%h/empty0",
                 k, bus.data_valid_o, bus.data_o, bus.fifo_empty_o, exp_seq[0]);
      end
      checks++;
      tick();
    end
    bus.data_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (bus.data_valid_o !== 1'b1 || bus.data_o !== exp_seq[k]) begin
        failures++;
        $display("FAIL bp_word%0d actual=%b/%h expected=1/%h", k, bus.data_valid_o, bus.data_o, exp_seq[k]);
      end
      checks++;
      tick();
    end
    if (bus.data_valid_o !== 1'b0 || bus.fifo_empty_o !== 1'b1) begin
      failures++;
      $display("FAIL bp_done actual=valid%b/empty%b expected=valid0/empty1", bus.data_valid_o, bus.fifo_empty_o);
    end
    checks++;
  endtask

  task automatic test_overflow();
    int waitc;
    logic [31:0] exp;
    do_reset();
    bus.data_ready_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive_ev(i);
      tick();
    end
    bus.ev_valid_i = 1'b0;
    // event 0 sits in the output register, 1..16 fill the FIFO, 17..19 are dropped
    if (bus.fifo_full_o !== 1'b1) begin failures++; $display("FAIL ovf_full actual=%b expected=1", bus.fifo_full_o); end
    checks++;
    if (bus.drop_cnt_o !== 16'd3) begin failures++; $display("FAIL ovf_drop actual=%0d expected=3", bus.drop_cnt_o); end
    checks++;
    bus.data_ready_i = 1'b1;
    for (int e = 0; e < 17; e++) begin
      for (int w = 0; w < 2; w++) begin
        exp = (w == 0) ? exp_w0(e) : exp_w1(e);
        waitc = 0;
        while (bus.data_valid_o !== 1'b1 && waitc < 10) begin
          tick();
          waitc++;
        end
        if (bus.data_valid_o !== 1'b1) begin
          failures++;
          $display("FAIL ovf_timeout ev%0d w%0d actual=valid%b expected=valid1", e, w, bus.data_valid_o);
        end else if (bus.data_o !== exp) begin
          failures++;
          $display("FAIL ovf_ev%0d_w%0d actual=%h expected=%h", e, w, bus.data_o, exp);
        end
        checks++;
        tick();
      end
    end
    if (bus.data_valid_o !== 1'b0 || bus.fifo_empty_o !== 1'b1 || bus.fifo_full_o !== 1'b0) begin
      failures++;
      $display("FAIL ovf_drained actual=v%b/e%b/f%b expected=v0/e1/f0", bus.data_valid_o, bus.fifo_empty_o, bus.fifo_full_o);
    end
    checks++;
  endtask

  task automatic test_streaming();
    do_reset();
    bus.data_ready_i = 1'b1;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          drive_ev(i);
          tick();
          bus.ev_valid_i = 1'b0;
          tick();
        end
      end
      begin
        int waitc;
        logic [31:0] exp;
        waitc = 0;
        while (bus.data_valid_o !== 1'b1 && waitc < 20) begin
          tick();
          waitc++;
        end
        for (int k = 0; k < 80; k++) begin
          exp = (k % 2 == 0) ? exp_w0(k / 2) : exp_w1(k / 2);
          if (bus.data_valid_o !== 1'b1 || bus.data_o !== exp) begin
            failures++;
            $display("FAIL stream_word%0d actual=%b/%h expected=1/%h", k, bus.data_valid_o, bus.data_o, exp);
          end
          checks++;
          tick();
        end
      end
    join
    if (bus.data_valid_o !== 1'b0 || bus.fifo_empty_o !== 1'b1 || bus.drop_cnt_o !== 16'd0) begin
      failures++;
      $display("FAIL stream_end actual=v%b/e%b/drop%0d expected=v0/e1/drop0",
               bus.data_valid_o, bus.fifo_empty_o, bus.drop_cnt_o);
    end
    checks++;
  endtask

  task automatic test_reset_in_w1();
    do_reset();
    bus.data_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_ev(i);
      tick();
    end
    bus.ev_valid_i = 1'b0;
    bus.data_ready_i = 1'b1;
    tick();
    bus.data_ready_i = 1'b0;
    if (bus.data_valid_o !== 1'b1 || bus.data_o !== exp_w1(0) || bus.fifo_empty_o !== 1'b0) begin
      failures++;
      $display("FAIL rstw1_pre actual=%b/%h/e%b expected=1/%h/e0", bus.data_valid_o, bus.data_o, bus.fifo_empty_o, exp_w1(0));
    end
    checks++;
    rst = 1'b1;
    drive_ev(9);
    tick();
    if (bus.data_o !== 32'h0 || bus.data_valid_o !== 1'b0 || bus.fifo_empty_o !== 1'b1 ||
        bus.fifo_full_o !== 1'b0 || bus.drop_cnt_o !== 16'd0) begin
      failures++;
      $display("FAIL rstw1_outputs actual=%h/v%b/e%b/f%b/d%0d expected=0/v0/e1/f0/d0",
               bus.data_o, bus.data_valid_o, bus.fifo_empty_o, bus.fifo_full_o, bus.drop_cnt_o);
    end
    checks++;
    rst = 1'b0;
    bus.ev_valid_i = 1'b0;
    bus.data_ready_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.data_valid_o !== 1'b0) begin
        failures++;
        $display("FAIL rstw1_quiet%0d actual=%b expected=0", k, bus.data_valid_o);
      end
      checks++;
    end
  endtask

  task automatic test_drop_saturation();
    do_reset();
    bus4.data_ready_i = 1'b0;
    for (int i = 0; i < 37; i++) begin
      bus4.ev_valid_i  = 1'b1;
      bus4.x_add_i     = ev_x(i);
      bus4.y_add_i     = ev_y(i);
      bus4.polarity_i  = ev_pol(i);
      bus4.timestamp_i = ev_ts(i);
      tick();
      if (i == 30) begin
        if (bus4.drop_cnt_o !== 4'hE || bus4.fifo_full_o !== 1'b1) begin
          failures++;
          $display("FAIL sat_pre actual=%h/f%b expected=e/f1", bus4.drop_cnt_o, bus4.fifo_full_o);
        end
        checks++;
      end
    end
    bus4.ev_valid_i = 1'b0;
    if (bus4.drop_cnt_o !== 4'hF) begin
      failures++;
      $display("FAIL sat_final actual=%h expected=f", bus4.drop_cnt_o);
    end
    checks++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.ev_valid_i    = 1'b0;
    bus.x_add_i       = '0;
    bus.y_add_i       = '0;
    bus.polarity_i    = '0;
    bus.timestamp_i   = '0;
    bus.data_ready_i  = 1'b0;
    bus4.ev_valid_i   = 1'b0;
    bus4.x_add_i      = '0;
    bus4.y_add_i      = '0;
    bus4.polarity_i   = '0;
    bus4.timestamp_i  = '0;
    bus4.data_ready_i = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_streaming();
    test_reset_in_w1();
    test_drop_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
